// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding depends on IMEM_LOADER_VERIFY_EN (readback verification).
package imem_pkg;

  localparam int IMEM_DEPTH_W = 12;
  localparam int IMEM_WORDS   = 1 << IMEM_DEPTH_W;

`ifdef IMEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;
`endif

  // True when the region [base, base+count) does not fit inside a 2^depth_w word memory.
  function automatic logic addr_out_of_range(input logic [29:0] base,
                                             input logic [31:0] count,
                                             input int unsigned depth_w);
    logic [32:0] lo;
    lo = 33'(base) & ((33'd1 << depth_w) - 33'd1);
    return ((base >> depth_w) != 30'd0) || ((lo + 33'(count)) > (33'd1 << depth_w));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Command, source-stream, BRAM port-B and status signals of the program loader.
interface imem_loader_if #(
  parameter int COUNT_W = 13
) ();

  logic               start;
  logic [29:0]        base_addr;
  logic [COUNT_W-1:0] word_count;
  logic               s_valid;
  logic [31:0]        s_data;
  logic               s_ready;
  logic               mem_web;
  logic [29:0]        mem_addrb;
  logic [31:0]        mem_dinb;
  logic [31:0]        mem_doutb;
  logic               cpu_stall;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] loaded_count;

  modport slave (
    input  start, base_addr, word_count, s_valid, s_data, mem_doutb,
    output s_ready, mem_web, mem_addrb, mem_dinb, cpu_stall, busy, done, error,
           loaded_count
  );

  modport master (
    output start, base_addr, word_count, s_valid, s_data, mem_doutb,
    input  s_ready, mem_web, mem_addrb, mem_dinb, cpu_stall, busy, done, error,
           loaded_count
  );

endinterface

// File: rtl/imem_loader.sv
// Streams a program into the instruction BRAM port B while stalling the CPU.
// Define IMEM_LOADER_VERIFY_EN to read the region back and compare checksums.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_W = IMEM_DEPTH_W,
  parameter int COUNT_W = 13
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] base_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] idx_q;
  logic [COUNT_W-1:0] loaded_q;
  logic [31:0]        sum_q;
  logic               err_q;
  logic               web_q;
  logic [29:0]        addr_q;
  logic [31:0]        din_q;

  logic               hs;
  logic               range_err;
  logic [COUNT_W-1:0] idx_inc;
  logic               last_word;
  logic [DEPTH_W-1:0] wr_off;

  assign hs        = bus.s_valid && (state_q == ST_LOAD);
  assign range_err = addr_out_of_range(bus.base_addr, 32'(bus.word_count), DEPTH_W);
  assign idx_inc   = idx_q + COUNT_W'(1);
  assign last_word = (idx_inc == count_q);
  assign wr_off    = base_q + idx_q[DEPTH_W-1:0];

`ifdef IMEM_LOADER_VERIFY_EN
  logic [COUNT_W-1:0] rd_idx_q;
  logic               rd_vld1_q;
  logic               rd_vld2_q;
  logic [31:0]        rb_sum_q;
  logic [COUNT_W-1:0] rd_idx_inc;
  logic               rd_last;
  logic [DEPTH_W-1:0] rd_off;
  logic [31:0]        rb_total;

  assign rd_idx_inc = rd_idx_q + COUNT_W'(1);
  assign rd_last    = (rd_idx_inc == count_q);
  assign rd_off     = base_q + rd_idx_q[DEPTH_W-1:0];
  // The final readback word arrives during CHECK, so fold it in before comparing.
  assign rb_total   = rb_sum_q + (rd_vld2_q ? bus.mem_doutb : 32'd0);
`else
  logic unused_doutb;
  assign unused_doutb = ^bus.mem_doutb;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (range_err || (bus.word_count == '0)) state_d = ST_DONE;
          else                                     state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (hs && last_word) begin
`ifdef IMEM_LOADER_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      ST_VERIFY: if (rd_last) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      loaded_q  <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      web_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
      rd_idx_q  <= '0;
      rd_vld1_q <= 1'b0;
      rd_vld2_q <= 1'b0;
      rb_sum_q  <= '0;
`endif
    end else begin
      web_q <= hs;
      if ((state_q == ST_IDLE) && bus.start) begin
        base_q   <= bus.base_addr[DEPTH_W-1:0];
        count_q  <= bus.word_count;
        err_q    <= range_err;
        idx_q    <= '0;
        loaded_q <= '0;
        sum_q    <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
        rd_idx_q <= '0;
        rb_sum_q <= '0;
`endif
      end
      if (hs) begin
        addr_q   <= 30'(wr_off);
        din_q    <= bus.s_data;
        idx_q    <= idx_inc;
        loaded_q <= loaded_q + COUNT_W'(1);
        sum_q    <= sum_q + bus.s_data;
      end
`ifdef IMEM_LOADER_VERIFY_EN
      // Address registered in VERIFY is seen by the BRAM next cycle; data one cycle after.
      rd_vld1_q <= (state_q == ST_VERIFY);
      rd_vld2_q <= rd_vld1_q;
      if (state_q == ST_VERIFY) begin
        addr_q   <= 30'(rd_off);
        rd_idx_q <= rd_idx_inc;
      end
      if (rd_vld2_q) rb_sum_q <= rb_sum_q + bus.mem_doutb;
      if ((state_q == ST_CHECK) && (rb_total != sum_q)) err_q <= 1'b1;
`endif
    end
  end

  assign bus.s_ready      = (state_q == ST_LOAD);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.cpu_stall    = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.error        = err_q;
  assign bus.loaded_count = loaded_q;
  assign bus.mem_web      = web_q;
  assign bus.mem_addrb    = addr_q;
  assign bus.mem_dinb     = din_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, a write scoreboard
// fed by the driver, a BRAM model, and hand-written reset / verify sequences.
module tb_imem_loader;

  localparam int COUNT_W = 13;

  typedef struct {
    logic [29:0] base;
    int          count;
    int          max_gap;
    logic [31:0] seed;
    logic        range_err;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_seen = 0;

  logic [31:0] mem [4096];
  logic        corrupt_en = 1'b0;
  logic [11:0] corrupt_addr = '0;
  wr_t         exp_q [$];
  vec_t        vecs [7];

  imem_loader_if #(.COUNT_W(COUNT_W)) m ();

  imem_loader #(.DEPTH_W(12), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port-B model: write-enable at the edge, 1-cycle registered read.
  always @(posedge clk) begin
    if (m.mem_web) mem[m.mem_addrb[11:0]] <= m.mem_dinb;
    m.mem_doutb <= mem[m.mem_addrb[11:0]] ^
                   ((corrupt_en && (m.mem_addrb[11:0] == corrupt_addr)) ? 32'h1 : 32'h0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && m.mem_web) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", m.mem_addrb, m.mem_dinb);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(m.mem_addrb), 64'(e.addr));
        check("wr_data", 64'(m.mem_dinb), 64'(e.data));
      end
    end
    if (!rst && m.done) done_seen++;
  end

  function automatic int exp_lat(input int count, input logic range_err);
    if (range_err || (count == 0)) return 1;
`ifdef IMEM_LOADER_VERIFY_EN
    return count + 3;
`else
    return 1;
`endif
  endfunction

  task automatic run_load(input logic [29:0] base, input int count, input int max_gap,
                          input logic [31:0] seed, input logic range_err,
                          input logic exp_err, input string tag);
    int start_cyc;
    int ref_cyc;
    int d0;
    int k;
    // A word offered while idle must be neither accepted nor written.
    m.s_valid = 1'b1;
    m.s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(m.s_ready), 64'd0);
    @(posedge clk); #1;
    m.s_valid = 1'b0;
    d0 = done_seen;
    m.start      = 1'b1;
    m.base_addr  = base;
    m.word_count = COUNT_W'(count);
    @(negedge clk);
    start_cyc = cyc;
    ref_cyc   = cyc;
    @(posedge clk); #1;
    m.start = 1'b0;
    if (!range_err) begin
      for (int i = 0; i < count; i++) begin
        k = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (k) begin
          m.s_valid = 1'b0;
          @(negedge clk);
          check({tag, "_gap_ready"}, 64'(m.s_ready), 64'd1);
          @(posedge clk); #1;
        end
        m.s_valid = 1'b1;
        m.s_data  = seed + 32'(i);
        @(negedge clk);
        check({tag, "_ready"}, 64'(m.s_ready), 64'd1);
        exp_q.push_back('{addr: base + 30'(i), data: seed + 32'(i)});
        ref_cyc = cyc;
        @(posedge clk); #1;
      end
      m.s_valid = 1'b0;
    end
    if (range_err || (count == 0)) ref_cyc = start_cyc;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m.done) break;
    end
    check({tag, "_done"}, 64'(m.done), 64'd1);
    check({tag, "_latency"}, 64'(cyc - ref_cyc), 64'(exp_lat(count, range_err)));
    check({tag, "_error"}, 64'(m.error), 64'(exp_err));
    check({tag, "_loaded"}, 64'(m.loaded_count), range_err ? 64'd0 : 64'(count));
    check({tag, "_stall_in_done"}, 64'(m.cpu_stall), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(m.done), 64'd0);
    check({tag, "_stall_released"}, 64'(m.cpu_stall), 64'd0);
    check({tag, "_busy_released"}, 64'(m.busy), 64'd0);
    check({tag, "_done_count"}, 64'(done_seen - d0), 64'd1);
    check({tag, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    m.start      = 1'b0;
    m.base_addr  = '0;
    m.word_count = '0;
    m.s_valid    = 1'b0;
    m.s_data     = '0;

    vecs[0] = '{base: 30'h10,   count: 4, max_gap: 0, seed: 32'hA,         range_err: 1'b0};
    vecs[1] = '{base: 30'h10,   count: 4, max_gap: 3, seed: 32'hA,         range_err: 1'b0};
    vecs[2] = '{base: 30'h20,   count: 0, max_gap: 0, seed: 32'h0,         range_err: 1'b0};
    vecs[3] = '{base: 30'hFFE,  count: 3, max_gap: 0, seed: 32'h100,       range_err: 1'b1};
    vecs[4] = '{base: 30'h4000, count: 3, max_gap: 0, seed: 32'h200,       range_err: 1'b1};
    vecs[5] = '{base: 30'hFFC,  count: 4, max_gap: 1, seed: 32'hCAFE_0000, range_err: 1'b0};
    vecs[6] = '{base: 30'h0,    count: 1, max_gap: 0, seed: 32'h1234_5678, range_err: 1'b0};

    // Reset state.
    @(negedge clk);
    check("rst_stall", 64'(m.cpu_stall), 64'd0);
    check("rst_busy", 64'(m.busy), 64'd0);
    check("rst_web", 64'(m.mem_web), 64'd0);
    check("rst_addr", 64'(m.mem_addrb), 64'd0);
    check("rst_din", 64'(m.mem_dinb), 64'd0);
    check("rst_done", 64'(m.done), 64'd0);
    check("rst_error", 64'(m.error), 64'd0);
    check("rst_loaded", 64'(m.loaded_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_load(vecs[v].base, vecs[v].count, vecs[v].max_gap, vecs[v].seed,
               vecs[v].range_err, vecs[v].range_err, $sformatf("vec%0d", v));
    end

    // Reset after 2 of 5 words, with an ignored start pulse mid-load.
    d0 = done_seen;
    m.start      = 1'b1;
    m.base_addr  = 30'h100;
    m.word_count = COUNT_W'(5);
    @(posedge clk); #1;
    m.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m.s_valid = 1'b1;
      m.s_data  = 32'h500 + 32'(i);
      m.start   = (i == 1);
      m.base_addr = (i == 1) ? 30'h300 : 30'h100;
      @(negedge clk);
      exp_q.push_back('{addr: 30'h100 + 30'(i), data: 32'h500 + 32'(i)});
      @(posedge clk); #1;
    end
    m.start   = 1'b0;
    m.s_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_loaded_before_rst", 64'(m.loaded_count), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 64'(m.cpu_stall), 64'd0);
    check("mid_rst_busy", 64'(m.busy), 64'd0);
    check("mid_rst_web", 64'(m.mem_web), 64'd0);
    check("mid_rst_addr", 64'(m.mem_addrb), 64'd0);
    check("mid_rst_din", 64'(m.mem_dinb), 64'd0);
    check("mid_rst_loaded", 64'(m.loaded_count), 64'd0);
    check("mid_rst_error", 64'(m.error), 64'd0);
    check("mid_rst_s_ready", 64'(m.s_ready), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_no_done", 64'(done_seen - d0), 64'd0);
    check("mid_rst_writes_seen", 64'(exp_q.size()), 64'd0);
    check("mid_rst_mem0", 64'(mem[12'h100]), 64'h500);
    check("mid_rst_mem1", 64'(mem[12'h101]), 64'h501);
    exp_q.delete();
    @(posedge clk); #1;
    run_load(30'h200, 3, 1, 32'h700, 1'b0, 1'b0, "after_rst");

`ifdef IMEM_LOADER_VERIFY_EN
    // Readback of base+1 is corrupted by the memory model.
    corrupt_en   = 1'b1;
    corrupt_addr = 12'h41;
    run_load(30'h40, 4, 0, 32'h900, 1'b0, 1'b1, "verify_corrupt");
    corrupt_en = 1'b0;
    run_load(30'h40, 4, 2, 32'hA00, 1'b0, 1'b0, "verify_clean");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
